// File: rtl/capture_ctrl.sv
// Capture sequencer: IDLE -> PREFILL -> ARMED -> TRIG -> POST -> DONE, with one-cycle STOP on abort.
// One cycle latency, all outputs registered; no backpressure, each host command is acted on the cycle it arrives.
module capture_ctrl #(
   parameter int CYCLE_COUNT_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cmd_start,
   input  logic                         cmd_abort,
   input  logic                         cmd_force_trig,
   input  logic                         trigger_match,
   input  logic                         write_enable,
   input  logic                         complete,
   input  logic [31:0]                  maxSampleCount,
   input  logic [31:0]                  preTriggerSampleCountMax,
   output logic                         idle,
   output logic                         preTrigger,
   output logic                         postTrigger,
   output logic                         triggered,
   output logic                         start,
   output logic                         abort,
   output logic [2:0]                   state_code,
   output logic                         cfg_error,
   output logic                         capture_done,
   output logic                         capture_aborted,
   output logic [CYCLE_COUNT_WIDTH-1:0] trigger_cycle
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PREFILL = 3'd1,
      S_ARMED   = 3'd2,
      S_TRIG    = 3'd3,
      S_POST    = 3'd4,
      S_STOP    = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   localparam logic [CYCLE_COUNT_WIDTH-1:0] CYC_ONE = CYCLE_COUNT_WIDTH'(1);

   state_t                       state_q;
   logic [31:0]                  max_q, pre_q, pre_cnt_q;
   logic [CYCLE_COUNT_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d, trigger_cycle_q;
   logic                         idle_q, pre_trig_q, post_trig_q, triggered_q, start_q, abort_q;
   logic                         cfg_error_q, done_q, aborted_q;
   logic                         cfg_ok, prefill_hit;

   always_comb begin
      // pre < max also rules out max == 0
      cfg_ok      = preTriggerSampleCountMax < maxSampleCount;
      prefill_hit = write_enable && (({1'b0, pre_cnt_q} + 33'd1) >= {1'b0, pre_q});
      cyc_cnt_d   = (&cyc_cnt_q) ? cyc_cnt_q : cyc_cnt_q + CYC_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         max_q           <= '0;
         pre_q           <= '0;
         pre_cnt_q       <= '0;
         cyc_cnt_q       <= '0;
         trigger_cycle_q <= '0;
         idle_q          <= 1'b1;
         pre_trig_q      <= 1'b0;
         post_trig_q     <= 1'b0;
         triggered_q     <= 1'b0;
         start_q         <= 1'b0;
         abort_q         <= 1'b0;
         cfg_error_q     <= 1'b0;
         done_q          <= 1'b0;
         aborted_q       <= 1'b0;
      end else begin
         start_q     <= 1'b0;
         triggered_q <= 1'b0;
         abort_q     <= 1'b0;
         if (state_q inside {S_PREFILL, S_ARMED, S_TRIG, S_POST}) begin
            cyc_cnt_q <= cyc_cnt_d;
         end
         // Entering STOP leaves the phase levels alone so the generator sees the end sample's phase.
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (cmd_start) begin
                  max_q <= maxSampleCount;
                  pre_q <= preTriggerSampleCountMax;
                  if (!cfg_ok) begin
                     cfg_error_q <= 1'b1;
                  end else begin
                     cfg_error_q <= 1'b0;
                     done_q      <= 1'b0;
                     aborted_q   <= 1'b0;
                     pre_cnt_q   <= '0;
                     cyc_cnt_q   <= '0;
                     start_q     <= 1'b1;
                     idle_q      <= 1'b0;
                     pre_trig_q  <= 1'b1;
                     state_q     <= (preTriggerSampleCountMax == 32'd0) ? S_ARMED : S_PREFILL;
                  end
               end
            end
            S_PREFILL: begin
               if (cmd_abort) begin
                  state_q <= S_STOP;
                  abort_q <= 1'b1;
               end else begin
                  if (write_enable) pre_cnt_q <= pre_cnt_q + 32'd1;
                  if (prefill_hit) state_q <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (cmd_abort) begin
                  state_q <= S_STOP;
                  abort_q <= 1'b1;
               end else if (trigger_match || cmd_force_trig) begin
                  state_q     <= S_TRIG;
                  triggered_q <= 1'b1;
               end
            end
            S_TRIG: begin
               trigger_cycle_q <= cyc_cnt_q;
               if (cmd_abort) begin
                  state_q <= S_STOP;
                  abort_q <= 1'b1;
               end else begin
                  state_q     <= S_POST;
                  pre_trig_q  <= 1'b0;
                  post_trig_q <= 1'b1;
               end
            end
            S_POST: begin
               if (cmd_abort) begin
                  state_q <= S_STOP;
                  abort_q <= 1'b1;
               end else if (complete) begin
                  state_q     <= S_DONE;
                  post_trig_q <= 1'b0;
                  idle_q      <= 1'b1;
                  done_q      <= 1'b1;
               end
            end
            S_STOP: begin
               state_q     <= S_IDLE;
               pre_trig_q  <= 1'b0;
               post_trig_q <= 1'b0;
               idle_q      <= 1'b1;
               aborted_q   <= 1'b1;
            end
            default: begin
               state_q     <= S_IDLE;
               pre_trig_q  <= 1'b0;
               post_trig_q <= 1'b0;
               idle_q      <= 1'b1;
            end
         endcase
      end
   end

   assign idle            = idle_q;
   assign preTrigger      = pre_trig_q;
   assign postTrigger     = post_trig_q;
   assign triggered       = triggered_q;
   assign start           = start_q;
   assign abort           = abort_q;
   assign state_code      = state_q;
   assign cfg_error       = cfg_error_q;
   assign capture_done    = done_q;
   assign capture_aborted = aborted_q;
   assign trigger_cycle   = trigger_cycle_q;

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Capture-sequencing state machine for the logic-capture datapath. It takes host commands (start, abort, force trigger) and the trigger-match input, and drives the phase signals `idle`, `preTrigger`, `postTrigger`, `triggered`, `start` and `abort` into the sample-packet generator. It counts that generator's `write_enable` strobes to decide when the pre-trigger window is full, and ends the capture on `complete`. It sits between the host register block and the sample generator.

## Interface
- `CYCLE_COUNT_WIDTH`, 32, width of the start-to-trigger cycle counter.
- `clk`  in  1  sample clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `cmd_start`  in  1  one-cycle host request to begin a capture.
- `cmd_abort`  in  1  one-cycle host request to stop a capture.
- `cmd_force_trig`  in  1  one-cycle software trigger.
- `trigger_match`  in  1  level from the trigger comparator.
- `write_enable`  in  1  packet-written strobe from the sample generator.
- `complete`  in  1  all-samples-taken strobe from the sample generator.
- `maxSampleCount`  in  32  total packets per capture; latched at start.
- `preTriggerSampleCountMax`  in  32  pre-trigger packets; latched at start.
- `idle`, `preTrigger`, `postTrigger`  out  1 each  phase levels.
- `triggered`  out  1  one-cycle strobe.
- `start`  out  1  one-cycle strobe.
- `abort`  out  1  one-cycle strobe.
- `state_code`  out  3  current state encoding.
- `cfg_error`  out  1  sticky; last start was rejected.
- `capture_done`  out  1  sticky; last capture completed normally.
- `capture_aborted`  out  1  sticky; last capture was aborted.
- `trigger_cycle`  out  CYCLE_COUNT_WIDTH  clk cycles from the start strobe to the triggered strobe.

## Operation
- All outputs are registered.
- Reset values:
  - `idle=1`; every other output is 0.
  - State is IDLE (`state_code=0`).
- States and encodings: IDLE=0, PREFILL=1, ARMED=2, TRIG=3, POST=4, STOP=5, DONE=6.
- IDLE / DONE, on `cmd_start`:
  - Latch both configuration inputs.
  - If `pre >= max` or `max == 0`: set `cfg_error`, stay in the current state, and leave the other status flags unchanged.
  - Otherwise: clear all three sticky flags, clear the pre-trigger counter and the cycle counter, pulse `start`, and go to PREFILL. Go to ARMED instead when `pre == 0`.
- PREFILL (`preTrigger=1`):
  - Count `write_enable`.
  - When the count plus the current strobe reaches `pre`, go to ARMED.
  - `trigger_match` and `cmd_force_trig` are ignored in this state.
- ARMED (`preTrigger=1`): on `trigger_match | cmd_force_trig`, go to TRIG.
- TRIG (exactly one cycle):
  - `triggered=1` and `preTrigger=1`, so the generator latches the trigger sample number.
  - Load `trigger_cycle` from the cycle counter.
  - Next state is POST.
- POST (`postTrigger=1`): on `complete`, set `capture_done` and go to DONE.
- Abort:
  - `cmd_abort` in PREFILL, ARMED, TRIG or POST goes to STOP.
  - It is ignored in IDLE, DONE and STOP.
- STOP (exactly one cycle):
  - `abort=1`, with `preTrigger`/`postTrigger` held at their values from the previous state so the generator latches the end sample.
  - Set `capture_aborted`; next state is IDLE.
- Phase levels: `idle=1` only in IDLE and DONE. `preTrigger` and `postTrigger` are never high together.
- Priority within a cycle: `cmd_abort` > `complete` > trigger > pre-fill count. `cmd_abort` together with `cmd_start` in IDLE: start is processed and abort is ignored.
- Cycle counter: increments every cycle from PREFILL/ARMED entry and saturates at all-ones.
- Pre-fill count: 32-bit compare, no wrap; `write_enable` outside PREFILL is not counted.

## Timing
- `cmd_start` at cycle N: at N+1, `start=1`, `idle=0`, `preTrigger=1`.
- Pre-fill: the `write_enable` that reaches `pre` at cycle N gives ARMED at N+1.
- `trigger_match` at cycle N in ARMED:
  - N+1: `triggered=1`, `preTrigger=1`.
  - N+2: `preTrigger=0`, `postTrigger=1`.
  - `trigger_cycle` = N+1 minus the cycle `start` was high.
- `complete` at cycle N in POST: N+1 gives `postTrigger=0`, `idle=1`, `capture_done=1`.
- `cmd_abort` at cycle N:
  - N+1: `abort=1` with the phase levels unchanged.
  - N+2: IDLE, all phase levels 0 except `idle`.
- Trigger input during STOP or TRIG: ignored.
- Reset mid-capture: IDLE on the next edge, all outputs back to reset values, no `abort` strobe.

## Test plan
- Normal capture, `max=8`, `pre=3`:
  - Stimulus: start; `write_enable` every 2nd cycle; trigger 5 cycles after ARMED; `complete` after 5 post-trigger writes.
  - Required: states 1→2→3→4→6, `triggered` high for exactly 1 cycle with `preTrigger=1`, `capture_done=1`, correct `trigger_cycle`.
- `pre=0`, `max=4`:
  - Stimulus: start.
  - Required: ARMED directly at N+1; an early `trigger_match` is accepted immediately.
- Early trigger:
  - Stimulus: `trigger_match` held high during PREFILL with `pre=5`.
  - Required: no `triggered` until the 5th write; TRIG occurs on the cycle after ARMED entry.
- Abort in each of PREFILL, ARMED and POST:
  - Required: one-cycle `abort` with the prior phase level still high, then IDLE; `capture_aborted=1`; `capture_done=0`.
- Configuration errors:
  - Stimulus: `pre=8`, `max=8` start; then `max=0` start.
  - Required: `cfg_error=1`, state stays IDLE, no `start` strobe.
  - Then a valid start clears `cfg_error`.
- Simultaneous events and reset:
  - `complete` and `cmd_abort` in the same POST cycle: STOP, with `abort` strobed.
  - Reset asserted in POST: next cycle `idle=1`, all other outputs 0.
